// File: rtl/sync_filter.sv
// Input conditioner for asynchronous lines: metastability chain, per-bit persistence
// filter and registered rise/fall/changed pulses, all in the clk domain.
module sync_filter #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int FILT  = (FILTER < 1) ? 1 : FILTER;
  localparam int CNT_W = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILT - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] upd;

  // Plain flop chain: nothing but the next flop may load from any stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VALUE;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[STAGES-1];

  // A differing bit must hold for FILT consecutive evaluations; any agreement restarts it.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != out[i]) begin
        if (cnt_q[i] == CNT_TC) upd[i] = 1'b1;
        else                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      out     <= RESET_VALUE;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      out     <= out ^ upd;
      rise    <= upd & s;
      fall    <= upd & ~s;
      changed <= |upd;
    end
  end

endmodule
